// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the board reset sequencer.
// The state encoding is visible on state_o, so the values are fixed.
package rst_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_cell.sv
// STAGES-deep synchroniser with asynchronous active-low clear.
// Used both for reset deassertion (d_i tied high) and for the PLL lock flag.
module sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // stage samples the value its neighbour held before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: waits for a stable PLL lock, holds everything in reset,
// then releases NUM_CH active-low reset channels one after another.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_CH         = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst_n,
    input  logic               locked,
    input  logic               sw_rst_req,
    output logic [NUM_CH-1:0]  rst_n_o,
    output logic               done,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

    logic rst_s_n;
    logic locked_s;

    rst_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic [NUM_CH-1:0] ch_raise;
    logic              done_q, done_d;

    // Reset assertion propagates asynchronously; release is aligned to cpu_clk.
    sync_cell #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (cpu_clk),
        .rst_n (cpu_rst_n),
        .d_i   (1'b1),
        .q_o   (rst_s_n)
    );

    sync_cell #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (cpu_clk),
        .rst_n (cpu_rst_n),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    // Next channel mask: one more channel raised, lowest channel first.
    always_comb begin
        ch_raise    = ch_q << 1;
        ch_raise[0] = 1'b1;
    end

    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        if (state_q != WAIT_LOCK && !locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            ch_d    = '0;
        end else if (state_q != WAIT_LOCK && sw_rst_req) begin
            state_d = HOLD;
            cnt_d   = '0;
            ch_d    = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD, RELEASE: begin
                    if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : STAG_LAST)) begin
                        cnt_d   = '0;
                        ch_d    = ch_raise;
                        state_d = (&ch_raise) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: ;
                default: state_d = WAIT_LOCK;
            endcase
        end
        done_d = (state_d == RUN);
    end

    always_ff @(posedge cpu_clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    assign rst_n_o = ch_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: three instances (defaults, fast 3-channel, 1-channel)
// checked every cycle against an elapsed-time model, plus directed spot checks.
module tb_rst_seq;

    logic cpu_clk    = 1'b0;
    logic cpu_rst_n  = 1'b0;
    logic locked     = 1'b0;
    logic sw_rst_req = 1'b0;

    logic [2:0] ch_a, ch_b;
    logic [0:0] ch_c;
    logic       done_a, done_b, done_c;
    logic [1:0] st_a, st_b, st_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #10 cpu_clk = ~cpu_clk;

    rst_seq dut_a (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_n_o(ch_a), .done(done_a), .state_o(st_a)
    );

    rst_seq #(.SYNC_STAGES(3), .NUM_CH(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut_b (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_n_o(ch_b), .done(done_b), .state_o(st_b)
    );

    rst_seq #(.SYNC_STAGES(3), .NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut_c (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_n_o(ch_c), .done(done_c), .state_o(st_c)
    );

    // Reference model: sequence described by edges elapsed since HOLD entry.
    int   p_stages[3] = '{2, 3, 3};
    int   p_nch[3]    = '{3, 3, 1};
    int   p_hold[3]   = '{16, 1, 1};
    int   p_stag[3]   = '{4, 1, 1};
    bit   m_wait[3];
    int   m_el[3];
    int   m_edges[3];
    logic [7:0] m_lsh[3];
    string nm[3] = '{"a", "b", "c"};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_wait[i]  = 1'b1;
            m_el[i]    = 0;
            m_edges[i] = 0;
            m_lsh[i]   = '0;
        end
    endtask

    task automatic model_step(input int i);
        bit ls;
        if (!cpu_rst_n) begin
            m_wait[i]  = 1'b1;
            m_el[i]    = 0;
            m_edges[i] = 0;
            m_lsh[i]   = '0;
            return;
        end
        ls = m_lsh[i][p_stages[i]-1];
        if (m_edges[i] < 1000) m_edges[i]++;
        if (m_edges[i] > p_stages[i]) begin
            if (m_wait[i]) begin
                if (ls) begin
                    m_wait[i] = 1'b0;
                    m_el[i]   = 0;
                end
            end else if (!ls) begin
                m_wait[i] = 1'b1;
            end else if (sw_rst_req) begin
                m_el[i] = 0;
            end else if (m_el[i] < 1000) begin
                m_el[i]++;
            end
        end
        m_lsh[i] = {m_lsh[i][6:0], locked};
    endtask

    function automatic logic [2:0] exp_ch(input int i);
        logic [2:0] r = '0;
        if (!m_wait[i])
            for (int k = 0; k < p_nch[i]; k++)
                r[k] = (m_el[i] >= p_hold[i] + k * p_stag[i]);
        return r;
    endfunction

    function automatic logic exp_done(input int i);
        return !m_wait[i] && (m_el[i] >= p_hold[i] + (p_nch[i] - 1) * p_stag[i]);
    endfunction

    function automatic logic [1:0] exp_state(input int i);
        if (m_wait[i])              return 2'd0;
        if (m_el[i] < p_hold[i])    return 2'd1;
        if (exp_done(i))            return 2'd3;
        return 2'd2;
    endfunction

    function automatic logic [2:0] obs_ch(input int i);
        case (i)
            0:       return ch_a;
            1:       return ch_b;
            default: return {2'b00, ch_c};
        endcase
    endfunction

    function automatic logic obs_done(input int i);
        case (i)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic [1:0] obs_state(input int i);
        case (i)
            0:       return st_a;
            1:       return st_b;
            default: return st_c;
        endcase
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check({nm[i], ".ch"},    32'(obs_ch(i)),    32'(exp_ch(i)));
            check({nm[i], ".done"},  32'(obs_done(i)),  32'(exp_done(i)));
            check({nm[i], ".state"}, 32'(obs_state(i)), 32'(exp_state(i)));
        end
    endtask

    // One rising edge: advance the model with the inputs seen at the edge,
    // then compare on the falling edge. Returns at a falling edge.
    task automatic cycle();
        @(posedge cpu_clk);
        for (int i = 0; i < 3; i++) model_step(i);
        @(negedge cpu_clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Assert reset for a few cycles and release it at a falling edge,
    // so the next rising edge is E1.
    task automatic do_reset();
        cpu_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        run(3);
        cpu_rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge cpu_clk);

        // Power-up with lock already high.
        locked = 1'b1;
        do_reset();
        run(3);
        check("a.state@E3", 32'(st_a), 32'd1);
        check("b.state@E3", 32'(st_b), 32'd0);
        run(1);
        check("b.state@E4", 32'(st_b), 32'd1);
        check("c.state@E4", 32'(st_c), 32'd1);
        run(1);
        check("b.ch@E5",   32'(ch_b),   32'h1);
        check("c.ch@E5",   32'(ch_c),   32'h1);
        check("c.state@E5", 32'(st_c),  32'd3);
        run(1);
        check("b.ch@E6",   32'(ch_b),   32'h3);
        run(1);
        check("b.ch@E7",   32'(ch_b),   32'h7);
        check("b.done@E7", 32'(done_b), 32'h1);
        run(11);
        check("a.ch@E18",  32'(ch_a),   32'h0);
        run(1);
        check("a.ch@E19",  32'(ch_a),   32'h1);
        run(4);
        check("a.ch@E23",  32'(ch_a),   32'h3);
        check("a.done@E23", 32'(done_a), 32'h0);
        run(4);
        check("a.ch@E27",  32'(ch_a),   32'h7);
        check("a.done@E27", 32'(done_a), 32'h1);

        // One-cycle lock drop while channel 0 is up.
        do_reset();
        run(20);
        locked = 1'b0;
        run(1);
        locked = 1'b1;
        run(2);
        check("lockloss.ch", 32'(ch_a), 32'h0);
        check("lockloss.state", 32'(st_a), 32'd0);
        run(30);
        check("relock.done", 32'(done_a), 32'h1);

        // Soft reset pulse in RUN.
        sw_rst_req = 1'b1;
        run(1);
        sw_rst_req = 1'b0;
        check("swrst.ch+1", 32'(ch_a), 32'h0);
        run(15);
        check("swrst.ch+16m", 32'(ch_a), 32'h0);
        run(1);
        check("swrst.ch+16", 32'(ch_a), 32'h1);
        run(8);
        check("swrst.ch+24", 32'(ch_a), 32'h7);

        // Soft reset in WAIT_LOCK is ignored.
        locked = 1'b0;
        run(5);
        sw_rst_req = 1'b1;
        run(1);
        sw_rst_req = 1'b0;
        check("swwait.state", 32'(st_a), 32'd0);
        locked = 1'b1;
        run(30);

        // Lock arrives after E10.
        locked = 1'b0;
        do_reset();
        run(10);
        locked = 1'b1;
        run(2);
        check("late.state@E12", 32'(st_a), 32'd0);
        run(1);
        check("late.state@E13", 32'(st_a), 32'd1);
        run(15);
        check("late.ch@E28", 32'(ch_a), 32'h0);
        run(1);
        check("late.ch@E29", 32'(ch_a), 32'h1);
        run(7);
        check("late.done@E36", 32'(done_a), 32'h0);
        run(1);
        check("late.done@E37", 32'(done_a), 32'h1);

        // Asynchronous reset between edges in RELEASE.
        do_reset();
        run(21);
        #3;
        cpu_rst_n = 1'b0;
        model_reset();
        #1;
        check("async.ch", 32'(ch_a), 32'h0);
        check("async.state", 32'(st_a), 32'd0);
        check("async.done", 32'(done_a), 32'h0);
        check_all();
        run(2);
        cpu_rst_n = 1'b1;
        run(30);
        check("async.restart.done", 32'(done_a), 32'h1);

        // Randomised lock drops, soft resets and board resets.
        for (int n = 0; n < 600; n++) begin
            if (!cpu_rst_n) begin
                if ($urandom_range(0, 2) == 0) cpu_rst_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                cpu_rst_n = 1'b0;
                model_reset();
            end
            if (locked) begin
                if ($urandom_range(0, 39) == 0) locked = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                locked = 1'b1;
            end
            sw_rst_req = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
